// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 16;
  localparam int unsigned MULT_ITERS = 16;
  localparam int unsigned MULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    NEG,
    DONE
  } mult_state_t;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder/subtractor: four 4-bit groups with group-level lookahead.
module cla_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] bx, g, p;
  logic [16:0] c;
  logic [3:0]  gg, gp;
  logic [4:0]  cg;

  always_comb begin
    bx    = b_i ^ {16{sub_i}};
    g     = a_i & bx;
    p     = a_i ^ bx;
    c     = '0;
    gg    = '0;
    gp    = '0;
    cg    = '0;
    cg[0] = sub_i;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16]  = cg[4];
    sum_o  = p ^ c[15:0];
    cout_o = c[16];
  end

endmodule

// File: rtl/mult_seq16.sv
// Iterative shift-and-add 16x16 multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN to add the signed_op port and the NEG (result negation) state.
module mult_seq16
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
  input  logic                 signed_op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  mult_state_t             state_q, state_d;
  logic [WIDTH-1:0]        acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        mcand_q, mcand_d;
  logic [MULT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      product_q, product_d;
  logic [WIDTH-1:0]        add_b, add_sum;
  logic                    add_cout;
`ifdef MULT_SIGNED_EN
  logic                    neg_q, neg_d;
`endif

  assign add_b = lo_q[0] ? mcand_q : '0;

  cla_16bit u_cla (
    .a_i    (acc_hi_q),
    .b_i    (add_b),
    .sub_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef MULT_SIGNED_EN
          // Multiply magnitudes; the sign is re-applied in NEG.
          mcand_d  = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
          lo_d     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
          mcand_d  = a;
          lo_d     = b;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Keep the adder carry: it becomes the top bit of acc_hi after the shift.
        acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
        lo_d     = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + MULT_CNT_W'(1);
        if (cnt_q == MULT_CNT_W'(MULT_ITERS - 1)) begin
`ifdef MULT_SIGNED_EN
          if (neg_q && (|{acc_hi_d, lo_d})) begin
            state_d = NEG;
          end else begin
            product_d = {acc_hi_d, lo_d};
            state_d   = DONE;
          end
`else
          product_d = {acc_hi_d, lo_d};
          state_d   = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG: begin
        product_d = ~{acc_hi_q, lo_q} + 1'b1;
        state_d   = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_hi_q  <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == RUN) || (state_q == NEG);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq16.sv
// Self-checking bench for mult_seq16: vector table, handshake corner cases, random vs. model.
module tb_mult_seq16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;
`ifdef MULT_SIGNED_EN
  logic        signed_op;
  localparam bit HasSigned = 1'b1;
`else
  localparam bit HasSigned = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_seq16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] exp_p;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic reference.
  function automatic logic [31:0] model_p(input logic [15:0] av, input logic [15:0] bv,
                                           input logic sv);
    longint p;
    if (sv) p = longint'($signed(av)) * longint'($signed(bv));
    else    p = longint'(av) * longint'(bv);
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [15:0] av, input logic [15:0] bv,
                                   input logic sv);
    longint p;
    p = longint'($signed(av)) * longint'($signed(bv));
    return (sv && p < 0) ? 18 : 17;
  endfunction

  task automatic drive(input logic st, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv);
    start = st;
    a     = av;
    b     = bv;
`ifdef MULT_SIGNED_EN
    signed_op = sv;
`else
    if (sv) $display("note: signed request issued to unsigned build");
`endif
  endtask

  // Starts one multiply from a negedge and waits (bounded) for done.
  task automatic do_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic [31:0] exp_p, input int exp_lat);
    int lat;
    int busy_n;
    logic [31:0] held;
    drive(1'b1, av, bv, sv);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    lat    = 1;
    busy_n = 0;
    while (!done && lat <= 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " product"}, product, exp_p);
    check({nm, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    check({nm, " busy in done"}, {31'b0, busy}, 32'd0);
    held = product;
    @(negedge clk);
    check({nm, " done single pulse"}, {31'b0, done}, 32'd0);
    check({nm, " product held"}, product, exp_p);
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{a: 16'd3,    b: 16'd5,    sgn: 1'b0, exp_p: 32'h0000000F, lat: 17});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, sgn: 1'b0, exp_p: 32'hFFFE0001, lat: 17});
    vecs.push_back('{a: 16'h0000, b: 16'hFFFF, sgn: 1'b0, exp_p: 32'h00000000, lat: 17});
    vecs.push_back('{a: 16'h0002, b: 16'h8000, sgn: 1'b0, exp_p: 32'h00010000, lat: 17});
    vecs.push_back('{a: 16'hFFFF, b: 16'h0001, sgn: 1'b0, exp_p: 32'h0000FFFF, lat: 17});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, sgn: 1'b0, exp_p: 32'h40000000, lat: 17});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{a: 16'hFFFD, b: 16'd5,    sgn: 1'b1, exp_p: 32'hFFFFFFF1, lat: 18});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, sgn: 1'b1, exp_p: 32'h40000000, lat: 17});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, sgn: 1'b1, exp_p: 32'h00000001, lat: 17});
    vecs.push_back('{a: 16'h7FFF, b: 16'h8000, sgn: 1'b1, exp_p: 32'hC0008000, lat: 18});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_p,
            vecs[i].lat);
    end

    // start held during RUN is ignored; start in the DONE cycle is accepted back-to-back.
    drive(1'b1, 16'd7, 16'd9, 1'b0);
    @(negedge clk);
    lat = 1;
    while (!done && lat <= 40) begin
      if (lat >= 15) drive(1'b1, 16'd2, 16'h8000, 1'b0);
      else           drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      @(negedge clk);
      lat++;
    end
    check("held start latency", 32'(lat), 32'd17);
    check("held start product", product, 32'h0000003F);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    check("b2b busy after done", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat <= 40) begin
      if (lat == 8) check("b2b product kept", product, 32'h0000003F);
      @(negedge clk);
      lat++;
    end
    check("b2b latency", 32'(lat), 32'd17);
    check("b2b product", product, 32'h00010000);
    @(negedge clk);

    // Reset in the middle of an operation.
    drive(1'b1, 16'h1234, 16'h0100, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset done", {31'b0, done}, 32'd0);
    check("midreset product", product, 32'd0);
    @(negedge clk);
    check("midreset idle", {31'b0, busy}, 32'd0);
    do_op("after reset", 16'd3, 16'd5, 1'b0, 32'h0000000F, 17);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = HasSigned ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 0) ra = 16'h8000;
      do_op($sformatf("rand%0d", i), ra, rb, rs, model_p(ra, rb, rs), model_lat(ra, rb, rs));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq16.md
# mult_seq16

Iterative 16×16 shift-and-add multiplier for the execute stage. It feeds operands into the team's existing 16-bit carry-lookahead adder one partial product per cycle and accumulates the 32-bit product. It sits beside the ALU, upstream of that adder, and gives the pipeline a start/busy/done handshake so the stall logic can hold the stage while a multiply is in flight.

## Interface
- `WIDTH`, 16: operand width. Only 16 is supported; the adder sub-module is fixed-width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply. Sampled only when `busy`=0.
- `a`  in  16  multiplicand, captured when start is accepted.
- `b`  in  16  multiplier, captured when start is accepted.
- `signed_op`  in  1  treat `a`/`b` as two's complement. Present only with `MULT_SIGNED_EN`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  32  result. Held until the next accepted start.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - NEG: `busy`=1. Exists only with `MULT_SIGNED_EN`.
  - DONE: `busy`=0, `done`=1.
- Reset (any state, including mid-operation):
  - State goes to IDLE.
  - `product`, the accumulator, the iteration counter, `busy` and `done` all clear to 0.
- Start acceptance:
  - Accepted when `start`=1 in IDLE or DONE. Acceptance in DONE gives back-to-back operation.
  - On acceptance: `acc_hi`←0, `lo`←b, `mcand`←a, `cnt`←0, go to RUN.
  - `start` in RUN or NEG is ignored, with no side effects.
- RUN, each cycle:
  - Adder inputs: `acc_hi` and (`lo[0]` ? `mcand` : 0), with sub=0.
  - Update: {carry, `acc_hi`, `lo`} ← {adder cout, adder sum, `lo`} >> 1.
  - `cnt` increments. The 17-bit {cout, sum} must be kept before the shift; truncating cout is a bug.
  - After iteration 16 (`cnt` wraps 15→0), {`acc_hi`, `lo`} is the unsigned product. Go to DONE, or to NEG for a negative signed result.
- DONE: `product` ← {`acc_hi`, `lo`} is registered on entry and `done` is high for exactly that cycle. The next state is RUN if `start`=1, otherwise IDLE.
- `product` is unchanged from DONE until the next DONE. An ignored start never disturbs it.

## Timing
- Start accepted at edge t.
- RUN occupies edges t+1 … t+16.
- Unsigned: `done`=1 and `product` valid in the cycle after edge t+16, i.e. 17 cycles after the start cycle.
- Signed with negation: NEG adds one cycle, so latency is 18.
- Signed with a non-negative result: latency is 17.
- `busy` rises in the cycle after acceptance and falls in the DONE cycle.
- No combinational path from `start` to `busy`/`done`.
- The adder's critical path plus the shift mux fits in one cycle.

## Configuration
- `MULT_SIGNED_EN` defined:
  - `signed_op` port exists.
  - When `signed_op`=1, the magnitudes of `a` and `b` are loaded and `neg` = a[15]^b[15] is registered.
  - NEG state: `product` ← two's-complement negation of the 32-bit result, in one cycle.
  - −32768 has magnitude 0x8000 and needs no special case. −32768 × −32768 = 0x40000000.
- `MULT_SIGNED_EN` undefined: no port, no NEG state, all operations unsigned, and latency is always 17.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` (IDLE, RUN, NEG, DONE);
  - `MULT_WIDTH`=16;
  - `MULT_ITERS`=16;
  - `MULT_CNT_W`=4.
- One sub-module: the existing `cla_16bit` adder, instantiated once with sub tied to 0.
- Counter, shift registers and FSM live in `mult_seq16`. The signed negation logic is local and inline.

## Test plan
- Basic: a=3, b=5, start for 1 cycle → `busy` for 16 cycles, `done` pulse 17 cycles after start, `product`=0x0000000F.
- Carry retention: a=0xFFFF, b=0xFFFF → `product`=0xFFFE0001. Catches a dropped adder cout.
- Busy and back-to-back:
  - `start` held with a=7, b=9 during RUN → ignored, result 0x3F.
  - `start` asserted in the DONE cycle with a=2, b=0x8000 → next `done` after 17 more cycles, `product`=0x00010000.
- Reset mid-op: start a=0x1234, b=0x0100, assert `rst` at iteration 8 → next cycle IDLE, `busy`=0, `done`=0, `product`=0. A subsequent 3×5 still yields 15.
- Signed (with `MULT_SIGNED_EN`):
  - `signed_op`=1, a=0xFFFD (−3), b=5 → `product`=0xFFFFFFF1, latency 18.
  - a=0x8000, b=0x8000 → `product`=0x40000000, latency 17.
- Zero: a=0, b=0xFFFF → `product`=0, latency 17, `done` pulses exactly once.
